// File: rtl/multi_chan_fifo_pkg.sv
// Shared types and helpers for the multi-channel FIFO: arbitration modes,
// width helpers and the grant-selection functions used by the output arbiter.
package multi_chan_fifo_pkg;

    typedef enum logic {
        ARB_RR   = 1'b0,
        ARB_PRIO = 1'b1
    } arb_mode_e;

    localparam int MAX_CHANNELS = 16;
    localparam int GW           = 4;

    function automatic int cw_of(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic int lw_of(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Round-robin: first requester after 'last', wrapping over n channels.
    function automatic logic [GW-1:0] rr_pick(input logic [MAX_CHANNELS-1:0] req,
                                              input logic [GW-1:0] last,
                                              input int n);
        int   idx;
        logic found;
        logic hit;
        rr_pick = last;
        found   = 1'b0;
        for (int i = 1; i <= MAX_CHANNELS; i++) begin
            idx     = (int'(last) + i) % n;
            hit     = !found && (i <= n) && req[4'(idx)];
            rr_pick = hit ? 4'(idx) : rr_pick;
            found   = found | hit;
        end
    endfunction

    function automatic logic [GW-1:0] prio_pick(input logic [MAX_CHANNELS-1:0] req);
        prio_pick = 4'd0;
        for (int i = MAX_CHANNELS - 1; i >= 0; i--) begin
            prio_pick = req[4'(i)] ? 4'(i) : prio_pick;
        end
    endfunction

endpackage

// File: rtl/multi_chan_fifo_chan_fifo.sv
// Single-channel circular FIFO with a registered occupancy count; the caller
// guarantees push only when not full and pop only when not empty.
module chan_fifo
    import multi_chan_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          wr_data,
    output logic [WIDTH-1:0]          head,
    output logic [lw_of(DEPTH)-1:0]   level,
    output logic                      full,
    output logic                      empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = lw_of(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;

    // Storage write; entries are only observed once level says they hold data.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave level unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push, pop})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign level = level_r;
    assign full  = (level_r == LW'(DEPTH));
    assign empty = (level_r == LW'(0));

endmodule

// File: rtl/multi_chan_fifo.sv
// CHANNELS independent FIFOs merged onto one registered output port by a
// round-robin or fixed-priority arbiter.
module multi_chan_fifo
    import multi_chan_fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int CHANNELS = 3,
    parameter int ARB_MODE = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [CHANNELS-1:0]                  in_valid,
    output logic [CHANNELS-1:0]                  in_ready,
    input  logic [CHANNELS*WIDTH-1:0]            in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [WIDTH-1:0]                     out_data,
    output logic [cw_of(CHANNELS)-1:0]           out_chan,
    output logic [CHANNELS*lw_of(DEPTH)-1:0]     level
);
    localparam int CW = cw_of(CHANNELS);
    localparam int LW = lw_of(DEPTH);

    logic [CHANNELS-1:0]     full_s;
    logic [CHANNELS-1:0]     empty_s;
    logic [CHANNELS-1:0]     push_s;
    logic [CHANNELS-1:0]     pop_s;
    logic [WIDTH-1:0]        head_s [CHANNELS];
    logic [MAX_CHANNELS-1:0] req_s;
    logic [GW-1:0]           grant_s;
    logic [WIDTH-1:0]        head_sel_s;
    logic                    free_s;
    logic                    any_req_s;

    logic                    out_valid_r;
    logic [WIDTH-1:0]        out_data_r;
    logic [CW-1:0]           out_chan_r;
    logic [GW-1:0]           last_grant_r;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        chan_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push    (push_s[c]),
            .pop     (pop_s[c]),
            .wr_data (in_data[c*WIDTH +: WIDTH]),
            .head    (head_s[c]),
            .level   (level[c*LW +: LW]),
            .full    (full_s[c]),
            .empty   (empty_s[c])
        );
        assign push_s[c]   = in_valid[c] & ~full_s[c];
        assign in_ready[c] = ~full_s[c];
    end

    // Arbiter: pick one non-empty channel whenever the output register can take a word.
    always_comb begin
        req_s                 = 16'h0000;
        req_s[CHANNELS-1:0]   = ~empty_s;
        free_s                = ~out_valid_r | out_ready;
        any_req_s             = |req_s;
        if (ARB_MODE == int'(ARB_PRIO)) begin
            grant_s = prio_pick(req_s);
        end else begin
            grant_s = rr_pick(req_s, last_grant_r, CHANNELS);
        end
        pop_s      = {CHANNELS{1'b0}};
        head_sel_s = {WIDTH{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            pop_s[c]   = free_s & any_req_s & (grant_s == 4'(c));
            head_sel_s = head_sel_s | ({WIDTH{grant_s == 4'(c)}} & head_s[c]);
        end
    end

    // Output register; data and channel hold their last value when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= {WIDTH{1'b0}};
            out_chan_r   <= {CW{1'b0}};
            last_grant_r <= 4'(CHANNELS - 1);
        end else if (free_s) begin
            if (any_req_s) begin
                out_valid_r  <= 1'b1;
                out_data_r   <= head_sel_s;
                out_chan_r   <= grant_s[CW-1:0];
                last_grant_r <= grant_s;
            end else begin
                out_valid_r  <= 1'b0;
            end
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_chan  = out_chan_r;

endmodule

// File: tb/tb_multi_chan_fifo.sv
// Bench for multi_chan_fifo: round-robin and fixed-priority instances share
// stimulus and are compared every cycle against queue-based reference models.
module tb_multi_chan_fifo;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int C  = 3;
    localparam int CW = 2;
    localparam int LW = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [C-1:0]   in_valid;
    logic [C*W-1:0] in_data;
    logic           out_ready;

    logic [C-1:0]    in_ready  [2];
    logic            out_valid [2];
    logic [W-1:0]    out_data  [2];
    logic [CW-1:0]   out_chan  [2];
    logic [C*LW-1:0] level     [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: index 0 is round-robin, index 1 is fixed priority.
    logic [W-1:0] mq [2][C][$];
    logic         m_ov   [2];
    logic [W-1:0] m_od   [2];
    int           m_oc   [2];
    int           m_last [2];

    int exp_seq [2][9] = '{'{0, 1, 2, 0, 1, 2, 0, 1, 2}, '{0, 0, 0, 1, 1, 1, 2, 2, 2}};

    always #5 clk = ~clk;

    multi_chan_fifo #(.WIDTH(W), .DEPTH(D), .CHANNELS(C), .ARB_MODE(0)) u_rr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]), .in_data(in_data),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]),
        .out_chan(out_chan[0]), .level(level[0])
    );

    multi_chan_fifo #(.WIDTH(W), .DEPTH(D), .CHANNELS(C), .ARB_MODE(1)) u_prio (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]), .in_data(in_data),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]),
        .out_chan(out_chan[1]), .level(level[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int m);
        logic [C-1:0] rdy;
        int g;
        int c;
        if (rst) begin
            for (int k = 0; k < C; k++) mq[m][k].delete();
            m_ov[m]   = 1'b0;
            m_od[m]   = 8'h00;
            m_oc[m]   = 0;
            m_last[m] = C - 1;
        end else begin
            for (int k = 0; k < C; k++) rdy[k] = (mq[m][k].size() < D);
            if (!m_ov[m] || out_ready) begin
                g = -1;
                for (int k = 0; k < C; k++) begin
                    c = (m == 1) ? k : (m_last[m] + 1 + k) % C;
                    if (g < 0 && mq[m][c].size() > 0) g = c;
                end
                if (g >= 0) begin
                    m_od[m]   = mq[m][g].pop_front();
                    m_oc[m]   = g;
                    m_ov[m]   = 1'b1;
                    m_last[m] = g;
                end else begin
                    m_ov[m] = 1'b0;
                end
            end
            for (int k = 0; k < C; k++) begin
                if (in_valid[k] && rdy[k]) mq[m][k].push_back(in_data[k*W +: W]);
            end
        end
    endtask

    task automatic check_all();
        logic [C*LW-1:0] lv;
        logic [C-1:0]    rdy;
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < C; k++) begin
                lv[k*LW +: LW] = 3'(mq[m][k].size());
                rdy[k]         = (mq[m][k].size() < D);
            end
            check_eq($sformatf("m%0d out_valid", m), 32'(out_valid[m]), 32'(m_ov[m]));
            check_eq($sformatf("m%0d out_data", m),  32'(out_data[m]),  32'(m_od[m]));
            check_eq($sformatf("m%0d out_chan", m),  32'(out_chan[m]),  32'(m_oc[m]));
            check_eq($sformatf("m%0d level", m),     32'(level[m]),     32'(lv));
            check_eq($sformatf("m%0d in_ready", m),  32'(in_ready[m]),  32'(rdy));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 3'b111;
        in_data   = {8'($urandom), 8'($urandom), 8'($urandom)};
        out_ready = 1'b0;
        step();
        step();
        for (int m = 0; m < 2; m++) begin
            check_eq("reset out_valid", 32'(out_valid[m]), 32'h0);
            check_eq("reset level",     32'(level[m]),     32'h0);
            check_eq("reset in_ready",  32'(in_ready[m]),  32'h7);
            check_eq("reset out_data",  32'(out_data[m]),  32'h0);
            check_eq("reset out_chan",  32'(out_chan[m]),  32'h0);
        end

        // Single word on channel 1: visible one edge after the push.
        rst       = 1'b0;
        in_valid  = 3'b010;
        in_data   = 24'h00A500;
        out_ready = 1'b1;
        step();
        in_valid = 3'b000;
        step();
        check_eq("single out_valid", 32'(out_valid[0]), 32'h1);
        check_eq("single out_data",  32'(out_data[0]),  32'hA5);
        check_eq("single out_chan",  32'(out_chan[0]),  32'h1);
        step();
        check_eq("single drained", 32'(out_valid[0]), 32'h0);

        // Back-pressure: five words fit (one in the output register), the sixth waits.
        out_ready = 1'b0;
        in_valid  = 3'b001;
        for (int k = 0; k < 6; k++) begin
            in_data = {16'h0000, 8'(8'h10 + k)};
            step();
        end
        check_eq("full level0",   32'(level[0][LW-1:0]), 32'h4);
        check_eq("full in_ready", 32'(in_ready[0][0]),   32'h0);
        check_eq("full out_data", 32'(out_data[0]),      32'h10);
        out_ready = 1'b1;
        step();
        step();
        in_valid = 3'b000;
        for (int k = 0; k < 7; k++) step();
        check_eq("drained valid", 32'(out_valid[0]), 32'h0);

        // Reset in the middle of buffered traffic.
        out_ready = 1'b0;
        in_valid  = 3'b111;
        for (int k = 0; k < 3; k++) begin
            in_data = {8'(8'h40 + k), 8'(8'h30 + k), 8'(8'h20 + k)};
            step();
        end
        check_eq("pre-reset valid", 32'(out_valid[0]), 32'h1);
        rst = 1'b1;
        step();
        check_eq("mid reset level", 32'(level[0]),     32'h0);
        check_eq("mid reset valid", 32'(out_valid[1]), 32'h0);
        rst = 1'b0;

        // Preload three words per channel, then drain and check grant order.
        for (int k = 0; k < 3; k++) begin
            in_data = {8'(8'h60 + k), 8'(8'h50 + k), 8'(8'h40 + k)};
            step();
        end
        in_valid  = 3'b000;
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            for (int m = 0; m < 2; m++) begin
                check_eq($sformatf("m%0d seq%0d valid", m, k), 32'(out_valid[m]), 32'h1);
                check_eq($sformatf("m%0d seq%0d chan", m, k),  32'(out_chan[m]),  32'(exp_seq[m][k]));
            end
            step();
        end

        // Randomised traffic with stalls and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 199) == 0);
            in_valid  = 3'($urandom);
            in_data   = {8'($urandom), 8'($urandom), 8'($urandom)};
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
